// File: rtl/tbus_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// tbus_sram_responder_pkg
//   Shared TBUS operation encodings, operation-type width, responder FSM state
//   encoding and wait-counter width for the TBUS SRAM responder.
// -----------------------------------------------------------------------------
package tbus_sram_responder_pkg;

    localparam int unsigned TBUS_OPTYPE_W = 2;

    typedef logic [TBUS_OPTYPE_W-1:0] tbus_optype_t;

    localparam tbus_optype_t TBUS_READ  = 2'b00;
    localparam tbus_optype_t TBUS_WRITE = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/tbus_sram_responder_sram.sv
// -----------------------------------------------------------------------------
// tbus_sram
//   Single-port 2^ADDR_W x 64 storage, bit-granular masked write, registered
//   read. Contents are not reset. The read register only updates on an enabled
//   read, so it holds its value between accesses.
// Ports:
//   i_clk    rising-edge clock
//   i_en     access enable (one access per enabled cycle)
//   i_we     1 = masked write, 0 = read
//   i_addr   word index
//   i_wdata  write data
//   i_wmask  per-bit write enable
//   o_rdata  registered read data
// -----------------------------------------------------------------------------
module tbus_sram #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [63:0]       i_wdata,
    input  logic [63:0]       i_wmask,
    output logic [63:0]       o_rdata
);

    logic [63:0] r_mem [0:(1 << ADDR_W)-1];
    logic [63:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= (r_mem[i_addr] & ~i_wmask) | (i_wdata & i_wmask);
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/tbus_sram_responder.sv
// -----------------------------------------------------------------------------
// tbus_sram_responder
//   TBUS responder backed by a 64-bit wide SRAM. Accepts one request at a time
//   in IDLE, waits ACCESS_LATENCY cycles, performs the access on the transition
//   into RESP and pulses tbus_operation_done for one cycle (with
//   tbus_access_fault for out-of-range addresses or reserved optypes).
// Ports:
//   clock                rising-edge clock
//   reset                synchronous active-high reset
//   tbus_index_valid     request valid
//   tbus_index_ready     responder can accept (IDLE and not in reset)
//   tbus_index           byte address
//   tbus_write_data      store data (already lane-shifted)
//   tbus_write_mask      bit-granular write enable
//   tbus_operation_type  TBUS_READ / TBUS_WRITE (others fault)
//   tbus_read_data       aligned 64-bit read word, 0 for writes and faults
//   tbus_operation_done  one-cycle response pulse
//   tbus_access_fault    qualifies tbus_operation_done
// -----------------------------------------------------------------------------
module tbus_sram_responder
    import tbus_sram_responder_pkg::*;
#(
    parameter int unsigned MEM_DEPTH_LOG  = 12,
    parameter int unsigned ACCESS_LATENCY = 2,
    parameter logic [63:0] BASE_ADDR      = 64'h8000_0000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     tbus_index_valid,
    output logic                     tbus_index_ready,
    input  logic [63:0]              tbus_index,
    input  logic [63:0]              tbus_write_data,
    input  logic [63:0]              tbus_write_mask,
    input  logic [TBUS_OPTYPE_W-1:0] tbus_operation_type,
    output logic [63:0]              tbus_read_data,
    output logic                     tbus_operation_done,
    output logic                     tbus_access_fault
);

    localparam logic [CNT_W-1:0] LAT       = CNT_W'(ACCESS_LATENCY);
    localparam logic [63:0]      MEM_BYTES = 64'd8 << MEM_DEPTH_LOG;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [63:0]        r_index;
    logic [63:0]        r_wdata;
    logic [63:0]        r_wmask;
    tbus_optype_t       r_optype;
    logic               r_done;
    logic               r_fault;
    logic               r_rd_sel;

    logic               w_handshake;
    logic               w_enter_resp;
    logic [63:0]        w_req_index;
    logic [63:0]        w_req_wdata;
    logic [63:0]        w_req_wmask;
    tbus_optype_t       w_req_optype;
    logic [63:0]        w_off;
    logic               w_in_range;
    logic               w_op_read;
    logic               w_op_write;
    logic               w_access_ok;
    logic               w_mem_en;
    logic [MEM_DEPTH_LOG-1:0] w_word;
    logic [63:0]        w_sram_rdata;

    assign tbus_index_ready = (r_state == ST_IDLE) & ~reset;
    assign w_handshake      = tbus_index_valid & tbus_index_ready;

    // With zero latency the access happens on the handshake edge itself, so the
    // request is taken straight from the ports; otherwise from the latched copy.
    always_comb begin
        w_enter_resp = 1'b0;
        w_req_index  = r_index;
        w_req_wdata  = r_wdata;
        w_req_wmask  = r_wmask;
        w_req_optype = r_optype;
        if (r_state == ST_IDLE) begin
            w_req_index  = tbus_index;
            w_req_wdata  = tbus_write_data;
            w_req_wmask  = tbus_write_mask;
            w_req_optype = tbus_operation_type;
            w_enter_resp = w_handshake && (LAT == '0);
        end else if (r_state == ST_WAIT) begin
            w_enter_resp = ~reset && (r_cnt == CNT_W'(1));
        end
    end

    // Full-width offset compare keeps wrap-around addresses below BASE out of range.
    assign w_off       = w_req_index - BASE_ADDR;
    assign w_in_range  = (w_req_index >= BASE_ADDR) && (w_off < MEM_BYTES);
    assign w_word      = w_off[MEM_DEPTH_LOG+2:3];
    assign w_op_read   = (w_req_optype == TBUS_READ);
    assign w_op_write  = (w_req_optype == TBUS_WRITE);
    assign w_access_ok = w_in_range & (w_op_read | w_op_write);
    assign w_mem_en    = w_enter_resp & w_access_ok;

    tbus_sram #(
        .ADDR_W (MEM_DEPTH_LOG)
    ) u_sram (
        .i_clk   (clock),
        .i_en    (w_mem_en),
        .i_we    (w_op_write),
        .i_addr  (w_word),
        .i_wdata (w_req_wdata),
        .i_wmask (w_req_wmask),
        .o_rdata (w_sram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
            r_rd_sel <= 1'b0;
        end else begin
            r_done  <= w_enter_resp;
            r_fault <= w_enter_resp & ~w_access_ok;
            if (w_enter_resp) begin
                r_rd_sel <= w_access_ok & w_op_read;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_handshake) begin
                        r_index  <= tbus_index;
                        r_wdata  <= tbus_write_data;
                        r_wmask  <= tbus_write_mask;
                        r_optype <= tbus_operation_type;
                        if (LAT == '0) begin
                            r_state <= ST_RESP;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= LAT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_RESP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The SRAM read register only moves on a read completion, so selecting it
    // only after a successful read keeps read_data stable between dones.
    assign tbus_read_data      = r_rd_sel ? w_sram_rdata : '0;
    assign tbus_operation_done = r_done;
    assign tbus_access_fault   = r_fault;

endmodule

// File: tb/tb_tbus_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_tbus_sram_responder
//   Self-checking bench for tbus_sram_responder: a default-latency instance and
//   a zero-latency instance, checked against a word-level memory model.
// -----------------------------------------------------------------------------
module tb_tbus_sram_responder;
    import tbus_sram_responder_pkg::*;

    localparam logic [63:0] BASE      = 64'h8000_0000;
    localparam int          LAT       = 2;
    localparam logic [63:0] MEM_BYTES = 64'd8 * 64'd4096;
    localparam logic [63:0] MEM0_BYTES = 64'd8 * 64'd16;

    logic        clk;
    logic        rst, valid, ready, done, fault;
    logic [63:0] index, wdata, wmask, rdata;
    logic [1:0]  op;

    logic        rst0, valid0, ready0, done0, fault0;
    logic [63:0] index0, wdata0, wmask0, rdata0;
    logic [1:0]  op0;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    bit mon_en = 0;

    logic [63:0] model [int];

    tbus_sram_responder #(
        .MEM_DEPTH_LOG (12),
        .ACCESS_LATENCY(LAT),
        .BASE_ADDR     (BASE)
    ) dut (
        .clock              (clk),
        .reset              (rst),
        .tbus_index_valid   (valid),
        .tbus_index_ready   (ready),
        .tbus_index         (index),
        .tbus_write_data    (wdata),
        .tbus_write_mask    (wmask),
        .tbus_operation_type(op),
        .tbus_read_data     (rdata),
        .tbus_operation_done(done),
        .tbus_access_fault  (fault)
    );

    tbus_sram_responder #(
        .MEM_DEPTH_LOG (4),
        .ACCESS_LATENCY(0),
        .BASE_ADDR     (BASE)
    ) dut0 (
        .clock              (clk),
        .reset              (rst0),
        .tbus_index_valid   (valid0),
        .tbus_index_ready   (ready0),
        .tbus_index         (index0),
        .tbus_write_data    (wdata0),
        .tbus_write_mask    (wmask0),
        .tbus_operation_type(op0),
        .tbus_read_data     (rdata0),
        .tbus_operation_done(done0),
        .tbus_access_fault  (fault0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // fault must never be seen without done
    always @(negedge clk) begin
        if (mon_en && !done) begin
            checks++;
            if (fault !== 1'b0) $display("FAIL fault_without_done cyc=%0d got=%b want=0", cyc, fault);
            else passes++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit in_range(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + MEM_BYTES);
    endfunction

    function automatic int word_of(input logic [63:0] a);
        return int'((a - BASE) / 8);
    endfunction

    // One complete transaction; latency is done cycle minus handshake cycle.
    task automatic bus_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] d,
                          input logic [63:0] m, output logic [63:0] rd, output logic f,
                          output int lat);
        int t_hs;
        int n;
        @(negedge clk);
        valid = 1'b1; op = o; index = a; wdata = d; wmask = m;
        n = 0;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        t_hs = cyc;
        @(negedge clk);
        valid = 1'b0;
        op    = 2'($urandom);
        index = {$urandom, $urandom};
        wdata = {$urandom, $urandom};
        wmask = {$urandom, $urandom};
        n = 0;
        while (!done && n < 50) begin @(negedge clk); n++; end
        if (done !== 1'b1) begin
            lat = -1; rd = 'x; f = 1'bx;
        end else begin
            lat = cyc - t_hs; rd = rdata; f = fault;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rst0 = 1'b1;
        valid = 1'b0; valid0 = 1'b0;
        op = TBUS_READ; index = '0; wdata = '0; wmask = '0;
        op0 = TBUS_READ; index0 = '0; wdata0 = '0; wmask0 = '0;
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", ready); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else passes++;
        checks++; if (fault !== 1'b0) $display("FAIL reset_fault got=%b want=0", fault); else passes++;
        checks++; if (rdata !== 64'h0) $display("FAIL reset_rdata got=%h want=0", rdata); else passes++;
        rst = 1'b0; rst0 = 1'b0;
        @(negedge clk);
        mon_en = 1;
        checks++; if (ready !== 1'b1) $display("FAIL post_reset_ready got=%b want=1", ready); else passes++;
    endtask

    task automatic test_read_after_reset();
        logic [63:0] rd; logic f; int lat;
        bus_op(TBUS_WRITE, BASE, 64'h1122334455667788, '1, rd, f, lat);
        model[0] = 64'h1122334455667788;
        bus_op(TBUS_READ, BASE, '0, '0, rd, f, lat);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (rdata !== 64'h0) $display("FAIL reset_clears_rdata got=%h want=0", rdata); else passes++;
        rst = 1'b0;
        bus_op(TBUS_READ, BASE, '0, '0, rd, f, lat);
        checks++; if (lat !== LAT + 1) $display("FAIL rar_latency got=%0d want=%0d", lat, LAT + 1); else passes++;
        checks++; if (rd !== 64'h1122334455667788) $display("FAIL rar_data got=%h want=1122334455667788", rd); else passes++;
        checks++; if (f !== 1'b0) $display("FAIL rar_fault got=%b want=0", f); else passes++;
    endtask

    task automatic test_masked_write();
        logic [63:0] rd; logic f; int lat;
        bus_op(TBUS_WRITE, BASE + 8, '1, '1, rd, f, lat);
        model[1] = '1;
        checks++; if (rd !== 64'h0) $display("FAIL write_rdata_zero got=%h want=0", rd); else passes++;
        checks++; if (f !== 1'b0) $display("FAIL write_fault got=%b want=0", f); else passes++;
        bus_op(TBUS_WRITE, BASE + 8, 64'h0000_00AB_0000_0000, 64'h0000_00FF_0000_0000, rd, f, lat);
        model[1] = 64'hFFFF_FFAB_FFFF_FFFF;
        checks++; if (lat !== LAT + 1) $display("FAIL write_latency got=%0d want=%0d", lat, LAT + 1); else passes++;
        bus_op(TBUS_READ, BASE + 8 + 5, '0, '0, rd, f, lat);
        checks++; if (rd !== 64'hFFFF_FFAB_FFFF_FFFF) $display("FAIL masked_write_data got=%h want=ffffffabffffffff", rd); else passes++;
    endtask

    task automatic test_out_of_range();
        logic [63:0] rd; logic f; int lat;
        bus_op(TBUS_READ, 64'h7FFF_FFF8, '0, '0, rd, f, lat);
        checks++; if (f !== 1'b1) $display("FAIL oor_low_fault got=%b want=1", f); else passes++;
        checks++; if (rd !== 64'h0) $display("FAIL oor_low_rdata got=%h want=0", rd); else passes++;
        checks++; if (lat !== LAT + 1) $display("FAIL oor_low_latency got=%0d want=%0d", lat, LAT + 1); else passes++;
        bus_op(TBUS_WRITE, BASE + 64'h8000, 64'hDEAD_BEEF_0BAD_F00D, '1, rd, f, lat);
        checks++; if (f !== 1'b1) $display("FAIL oor_high_fault got=%b want=1", f); else passes++;
        bus_op(TBUS_READ, BASE, '0, '0, rd, f, lat);
        checks++; if (rd !== model[0]) $display("FAIL oor_mem_unchanged got=%h want=%h", rd, model[0]); else passes++;
        bus_op(TBUS_WRITE, BASE + 64'h7FF8, 64'hCAFE_0000_1234_5678, '1, rd, f, lat);
        model[4095] = 64'hCAFE_0000_1234_5678;
        checks++; if (f !== 1'b0) $display("FAIL top_word_fault got=%b want=0", f); else passes++;
        bus_op(TBUS_READ, BASE + 64'h7FFF, '0, '0, rd, f, lat);
        checks++; if (rd !== model[4095]) $display("FAIL top_word_data got=%h want=%h", rd, model[4095]); else passes++;
        bus_op(2'b10, BASE, '0, '1, rd, f, lat);
        checks++; if (f !== 1'b1 || rd !== 64'h0) $display("FAIL reserved_op got=%b/%h want=1/0", f, rd); else passes++;
        bus_op(2'b11, BASE, '0, '1, rd, f, lat);
        checks++; if (f !== 1'b1) $display("FAIL reserved_op3 got=%b want=1", f); else passes++;
        bus_op(TBUS_READ, BASE, '0, '0, rd, f, lat);
        checks++; if (rd !== model[0]) $display("FAIL reserved_no_effect got=%h want=%h", rd, model[0]); else passes++;
    endtask

    task automatic test_random();
        int words[8] = '{0, 1, 2, 3, 4, 5, 4094, 4095};
        logic [63:0] rd, a, d, m, exp_rd; logic f, exp_f; int lat, kind, w;
        logic [1:0] o;
        foreach (words[i]) begin
            d = {$urandom, $urandom};
            bus_op(TBUS_WRITE, BASE + 64'(words[i]) * 8, d, '1, rd, f, lat);
            model[words[i]] = d;
        end
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            w = words[$urandom_range(0, 7)];
            a = BASE + 64'(w) * 8 + 64'($urandom_range(0, 7));
            o = ($urandom_range(0, 1) == 0) ? TBUS_READ : TBUS_WRITE;
            d = {$urandom, $urandom};
            m = {$urandom, $urandom};
            if (kind == 0) a = ($urandom_range(0, 1) == 0) ? BASE - 1 - 64'($urandom_range(0, 999))
                                                          : BASE + MEM_BYTES + 64'($urandom_range(0, 999));
            if (kind == 1) o = 2'($urandom_range(2, 3));
            if (!in_range(a) || (o != TBUS_READ && o != TBUS_WRITE)) begin
                exp_f = 1'b1; exp_rd = '0;
            end else if (o == TBUS_WRITE) begin
                exp_f = 1'b0; exp_rd = '0;
                model[word_of(a)] = (model[word_of(a)] & ~m) | (d & m);
            end else begin
                exp_f = 1'b0; exp_rd = model[word_of(a)];
            end
            bus_op(o, a, d, m, rd, f, lat);
            checks++;
            if (lat !== LAT + 1 || f !== exp_f || rd !== exp_rd)
                $display("FAIL random[%0d] op=%0d addr=%h got lat=%0d f=%b rd=%h want lat=%0d f=%b rd=%h",
                         i, o, a, lat, f, rd, LAT + 1, exp_f, exp_rd);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        int hs[$]; int dn[$]; logic [63:0] got[$];
        int idx = 0; bit pending = 0;
        @(negedge clk);
        valid = 1'b1; op = TBUS_READ; index = BASE; wdata = '0; wmask = '0;
        for (int c = 0; c < 20; c++) begin
            if (pending) begin
                idx++; pending = 0;
                if (idx < 3) index = BASE + 64'(idx) * 8; else valid = 1'b0;
            end
            if (done) begin
                dn.push_back(cyc); got.push_back(rdata);
            end else if (dn.size() > 0) begin
                checks++;
                if (rdata !== got[$]) $display("FAIL b2b_rdata_hold cyc=%0d got=%h want=%h", cyc, rdata, got[$]);
                else passes++;
            end
            if (valid && ready) begin hs.push_back(cyc); pending = 1; end
            @(negedge clk);
        end
        valid = 1'b0;
        checks++; if (hs.size() != 3 || dn.size() != 3)
            $display("FAIL b2b_counts got hs=%0d done=%0d want 3/3", hs.size(), dn.size()); else passes++;
        if (hs.size() == 3 && dn.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dn[i] - hs[0] != 3 + 4 * i || got[i] !== model[i])
                    $display("FAIL b2b_req%0d got dt=%0d data=%h want dt=%0d data=%h",
                             i, dn[i] - hs[0], got[i], 3 + 4 * i, model[i]);
                else passes++;
            end
            checks++; if (hs[2] - hs[0] != 8) $display("FAIL b2b_accept_spacing got=%0d want=8", hs[2] - hs[0]); else passes++;
        end
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] rd; logic f; int lat, n, seen;
        @(negedge clk);
        valid = 1'b1; op = TBUS_WRITE; index = BASE + 40; wdata = ~model[5]; wmask = '1;
        n = 0;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b0) $display("FAIL mid_reset_ready got=%b want=0", ready); else passes++;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) $display("FAIL mid_reset_no_done got=%0d want=0", seen); else passes++;
        bus_op(TBUS_READ, BASE + 40, '0, '0, rd, f, lat);
        checks++; if (rd !== model[5]) $display("FAIL mid_reset_no_write got=%h want=%h", rd, model[5]); else passes++;
    endtask

    task automatic test_latency0();
        logic [63:0] d; int n;
        d = {$urandom, $urandom};
        @(negedge clk);
        valid0 = 1'b1; op0 = TBUS_WRITE; index0 = BASE + 24; wdata0 = d; wmask0 = '1;
        n = 0;
        while (!ready0 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++; if (done0 !== 1'b1 || fault0 !== 1'b0) $display("FAIL lat0_write_done got=%b/%b want=1/0", done0, fault0); else passes++;
        checks++; if (ready0 !== 1'b0) $display("FAIL lat0_ready_in_resp got=%b want=0", ready0); else passes++;
        op0 = TBUS_READ;
        @(negedge clk);
        checks++; if (done0 !== 1'b0) $display("FAIL lat0_done_single got=%b want=0", done0); else passes++;
        checks++; if (ready0 !== 1'b1) $display("FAIL lat0_next_accept got=%b want=1", ready0); else passes++;
        @(negedge clk);
        valid0 = 1'b0;
        checks++; if (done0 !== 1'b1 || rdata0 !== d) $display("FAIL lat0_read got done=%b data=%h want 1/%h", done0, rdata0, d); else passes++;
        @(negedge clk);
        valid0 = 1'b1; op0 = TBUS_READ; index0 = BASE + MEM0_BYTES;
        @(negedge clk);
        valid0 = 1'b0;
        checks++; if (done0 !== 1'b1 || fault0 !== 1'b1 || rdata0 !== 64'h0)
            $display("FAIL lat0_oor got done=%b fault=%b data=%h want 1/1/0", done0, fault0, rdata0); else passes++;
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_masked_write();
        test_out_of_range();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        test_latency0();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
